elm_hidden_layer_engine: RTL

ELM_HIDDEN_LAYER_ENGINE -- requirements
Module: elm_hidden_layer_engine

---
 rtl/elm_hidden_layer_engine.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/elm_hidden_layer_engine.sv
// ELM hidden layer: per neuron, streams 32 weight-ROM words, accumulates weights of lit pixels,
// and emits a clipped, right-shifted activation over a valid/ready handshake.
module elm_hidden_layer_engine #(
  parameter int N_HIDDEN = 128,
  parameter int SHIFT    = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:256] image_256_bit,
  input  logic         update,
  output logic         weight_rd_en,
  output logic [11:0]  weight_addr,
  input  logic [63:0]  weight_data,
  output logic [7:0]   h_value,
  output logic [6:0]   h_index,
  output logic         h_valid,
  input  logic         h_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_EMIT,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_update_prev;
  logic [255:0]        r_image;
  logic [6:0]          r_n;
  logic [4:0]          r_k;
  logic [4:0]          r_k_d;
  logic                r_acc_en;
  logic signed [15:0]  r_acc;
  logic [7:0]          r_h_value;
  logic [6:0]          r_h_index;

  logic                w_update_rise;
  logic                w_transfer;
  logic                w_last_neuron;
  logic [7:0]          w_chunk;
  logic signed [15:0]  w_term [8];
  logic signed [15:0]  w_chunk_sum;
  logic [14:0]         w_acc_pos;
  logic [14:0]         w_shifted;
  logic [7:0]          w_act;

  assign w_update_rise = update & ~r_update_prev;
  assign w_transfer    = (r_state == S_EMIT) & h_ready;
  assign w_last_neuron = (r_n == 7'(N_HIDDEN - 1));

  // Image bit 1 sits in r_image[255]; chunk k covers bits 255-8k down to 248-8k.
  assign w_chunk = r_image[{~r_k_d, 3'b111} -: 8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_term
    assign w_term[gi] = w_chunk[7-gi]
                      ? {{8{weight_data[63-8*gi]}}, weight_data[63-8*gi -: 8]}
                      : 16'sd0;
  end

  always_comb begin
    w_chunk_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_chunk_sum = w_chunk_sum + w_term[i];
    end
  end

  assign w_acc_pos = r_acc[15] ? 15'd0 : r_acc[14:0];
  assign w_shifted = w_acc_pos >> SHIFT;
  assign w_act     = (w_shifted > 15'd255) ? 8'd255 : w_shifted[7:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_update_rise) w_state_next = S_FETCH;
      S_FETCH:  if (r_k == 5'd31) w_state_next = S_DRAIN;
      S_DRAIN:  if (!r_acc_en) w_state_next = S_EMIT;
      S_EMIT:   if (w_transfer) w_state_next = w_last_neuron ? S_FINISH : S_FETCH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_update_prev <= 1'b0;
      r_image       <= '0;
      r_n           <= '0;
      r_k           <= '0;
      r_k_d         <= '0;
      r_acc_en      <= 1'b0;
      r_acc         <= '0;
      r_h_value     <= '0;
      r_h_index     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_update_prev <= update;
      r_acc_en      <= weight_rd_en;
      r_k_d         <= r_k;
      // ROM data arrives one cycle after the read, so accumulation trails the fetch by one.
      if (r_acc_en) r_acc <= r_acc + w_chunk_sum;
      case (r_state)
        S_IDLE: begin
          if (w_update_rise) begin
            r_image <= image_256_bit;
            r_n     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
          end
        end
        S_FETCH: r_k <= r_k + 5'd1;
        S_DRAIN: begin
          if (!r_acc_en) begin
            r_h_value <= w_act;
            r_h_index <= r_n;
          end
        end
        S_EMIT: begin
          if (w_transfer && !w_last_neuron) begin
            r_n   <= r_n + 7'd1;
            r_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign weight_rd_en = (r_state == S_FETCH);
  assign weight_addr  = {r_n, r_k};
  assign h_value      = r_h_value;
  assign h_index      = r_h_index;
  assign h_valid      = (r_state == S_EMIT);
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FINISH);

endmodule
